// File: rtl/cic_pkg.sv
// cic_pkg: shared defaults and accumulator width derivation for the CIC decimator
package cic_pkg;

    localparam int IN_W_DEF   = 17;
    localparam int STAGES_DEF = 3;
    localparam int RATE_W_DEF = 8;

    // Bit growth of an N-stage, M=1 CIC is N*log2(Rmax); RATE_W bounds log2(Rmax).
    function automatic int acc_w(input int in_w, input int stages, input int rate_w);
        return in_w + stages * rate_w;
    endfunction

endpackage

// File: rtl/cic_channel.sv
// cic_channel: integrator chain, decimated capture and comb chain for one channel
module cic_channel
    import cic_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int ACC_W  = acc_w(IN_W_DEF, STAGES_DEF, RATE_W_DEF),
    parameter int OUT_W  = ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [STAGES:0]         en,
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y
);

    logic signed [ACC_W-1:0] integ_q [STAGES];
    logic signed [ACC_W-1:0] integ_d [STAGES];
    logic signed [ACC_W-1:0] src     [STAGES];
    logic signed [ACC_W-1:0] cin     [STAGES];
    logic signed [ACC_W-1:0] comb_q  [STAGES];
    logic signed [ACC_W-1:0] comb_d  [STAGES];
    logic signed [ACC_W-1:0] dly_q   [STAGES];
    logic signed [ACC_W-1:0] dly_d   [STAGES];
    logic signed [ACC_W-1:0] dec_q, dec_d, shifted;

    // Integrators wrap modulo 2^ACC_W; combs advance only when their token arrives.
    always_comb begin
        src[0] = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
        cin[0] = dec_q;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = integ_q[k-1];
            cin[k] = comb_q[k-1];
        end
        dec_d = en[0] ? integ_q[STAGES-1] : dec_q;
        for (int k = 0; k < STAGES; k++) begin
            integ_d[k] = in_valid ? integ_q[k] + src[k] : integ_q[k];
            comb_d[k]  = en[k+1] ? cin[k] - dly_q[k] : comb_q[k];
            dly_d[k]   = en[k+1] ? cin[k] : dly_q[k];
        end
    end

    // State registers for integrators, decimated sample, comb outputs and comb delays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            dec_q <= dec_d;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= integ_d[k];
                comb_q[k]  <= comb_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

    assign shifted = comb_q[STAGES-1] >>> (ACC_W - OUT_W);
    assign y       = shifted[OUT_W-1:0];

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: dual-channel I/Q CIC decimator with run-time programmable rate
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int OUT_W  = 41
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    input  logic [RATE_W-1:0]       rate,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q
);

    localparam int ACC_W = acc_w(IN_W, STAGES, RATE_W);

    logic [RATE_W-1:0] cnt_q, cnt_d, rate_eff;
    logic [STAGES+1:0] tok_q, tok_d;
    logic              bnd;

    // Boundary detection samples the rate; the token walks capture, each comb, then the output strobe.
    always_comb begin
        bnd      = in_valid && (cnt_q == '0);
        rate_eff = (rate == '0) ? RATE_W'(1) : rate;
        cnt_d    = !in_valid ? cnt_q : bnd ? rate_eff - RATE_W'(1) : cnt_q - RATE_W'(1);
        tok_d    = {tok_q[STAGES:0], bnd};
    end

    // Shared decimation counter and valid-token shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tok_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tok_q <= tok_d;
        end
    end

    assign out_valid = tok_q[STAGES+1];

    cic_channel #(.IN_W(IN_W), .STAGES(STAGES), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_chan_i (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .en       (tok_q[STAGES:0]),
        .x        (in_i),
        .y        (out_i)
    );

    cic_channel #(.IN_W(IN_W), .STAGES(STAGES), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_chan_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .en       (tok_q[STAGES:0]),
        .x        (in_q),
        .y        (out_q)
    );

endmodule
